// File: rtl/exe_stage_pkg.sv
// Shared widths, execute-command and shift-type codes for the EXE stage.
package exe_stage_pkg;

   localparam int ADDRESS_LEN         = 32;
   localparam int REGISTER_LEN        = 32;
   localparam int EXECUTE_COMMAND_LEN = 4;
   localparam int SHIFT_OPERAND_LEN   = 12;
   localparam int REGFILE_ADDRESS_LEN = 4;

   typedef enum logic [EXECUTE_COMMAND_LEN-1:0] {
      EXE_MOV = 4'b0001,
      EXE_MVN = 4'b1001,
      EXE_ADD = 4'b0010,
      EXE_ADC = 4'b0011,
      EXE_SUB = 4'b0100,
      EXE_SBC = 4'b0101,
      EXE_AND = 4'b0110,
      EXE_ORR = 4'b0111,
      EXE_EOR = 4'b1000
   } exe_cmd_e;

   typedef enum logic [1:0] {
      SHIFT_LSL = 2'b00,
      SHIFT_LSR = 2'b01,
      SHIFT_ASR = 2'b10,
      SHIFT_ROR = 2'b11
   } shift_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Val2 generator: memory offset, rotated immediate, or shifted Rm.
module val2_generator
   import exe_stage_pkg::*;
#(
   parameter int REG_W  = REGISTER_LEN,
   parameter int SHOP_W = SHIFT_OPERAND_LEN
) (
   input  logic [REG_W-1:0]  val_rm,
   input  logic [SHOP_W-1:0] shift_operand,
   input  logic              mem_op,
   input  logic              immediate,
   output logic [REG_W-1:0]  val2
);

   logic [REG_W-1:0]   imm_ext;
   logic [4:0]         imm_rot;
   logic [4:0]         sh_amt;
   logic [2*REG_W-1:0] imm_dbl;
   logic [2*REG_W-1:0] rm_dbl;
   logic [REG_W-1:0]   rm_shifted;

   assign imm_ext = REG_W'(shift_operand[7:0]);
   assign imm_rot = {shift_operand[11:8], 1'b0};
   assign sh_amt  = shift_operand[11:7];

   // Rotates are taken from the low half of a doubled word shifted right.
   assign imm_dbl = {imm_ext, imm_ext} >> imm_rot;
   assign rm_dbl  = {val_rm, val_rm} >> sh_amt;

   always_comb begin
      rm_shifted = val_rm;
      case (shift_e'(shift_operand[6:5]))
         SHIFT_LSL: rm_shifted = val_rm << sh_amt;
         SHIFT_LSR: rm_shifted = val_rm >> sh_amt;
         SHIFT_ASR: rm_shifted = REG_W'($signed(val_rm) >>> sh_amt);
         SHIFT_ROR: rm_shifted = rm_dbl[REG_W-1:0];
         default:   rm_shifted = val_rm;
      endcase
   end

   always_comb begin
      val2 = rm_shifted;
      if (mem_op)
         val2 = REG_W'(shift_operand);
      else if (immediate)
         val2 = imm_dbl[REG_W-1:0];
   end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: Val2, ALU, NZCV register, branch target, EXE/MEM register.
// Build option FORWARDING_EN adds operand forwarding muxes and their ports.
module exe_stage
   import exe_stage_pkg::*;
#(
   parameter int ADDR_W = ADDRESS_LEN,
   parameter int REG_W  = REGISTER_LEN,
   parameter int CMD_W  = EXECUTE_COMMAND_LEN,
   parameter int SHOP_W = SHIFT_OPERAND_LEN,
   parameter int RF_AW  = REGFILE_ADDRESS_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              wb_enable_in,
   input  logic              branch_taken_in,
   input  logic              status_write_enable_in,
   input  logic [CMD_W-1:0]  execute_command_in,
   input  logic [REG_W-1:0]  val_rn_in,
   input  logic [REG_W-1:0]  val_rm_in,
   input  logic              immediate_in,
   input  logic [23:0]       signed_immediate_in,
   input  logic [SHOP_W-1:0] shift_operand_in,
   input  logic [RF_AW-1:0]  dest_reg_in,
`ifdef FORWARDING_EN
   input  logic [1:0]        sel_src1,
   input  logic [1:0]        sel_src2,
   input  logic [REG_W-1:0]  mem_fwd_val,
   input  logic [REG_W-1:0]  wb_fwd_val,
`endif
   output logic              branch_taken_out,
   output logic [ADDR_W-1:0] branch_address_out,
   output logic [3:0]        status_out,
   output logic [REG_W-1:0]  alu_result_out,
   output logic [REG_W-1:0]  store_data_out,
   output logic [RF_AW-1:0]  dest_reg_out,
   output logic              mem_read_out,
   output logic              mem_write_out,
   output logic              wb_enable_out
);

   logic [REG_W-1:0] rn;
   logic [REG_W-1:0] rm;
   logic [REG_W-1:0] val2;
   logic [REG_W-1:0] result;
   logic [REG_W:0]   sum;
   logic             cmd_valid;
   logic             is_arith;
   logic             is_sub;
   nzcv_t            status;
   nzcv_t            nzcv_next;

`ifdef FORWARDING_EN
   always_comb begin
      case (sel_src1)
         2'b01:   rn = mem_fwd_val;
         2'b10:   rn = wb_fwd_val;
         default: rn = val_rn_in;
      endcase
      case (sel_src2)
         2'b01:   rm = mem_fwd_val;
         2'b10:   rm = wb_fwd_val;
         default: rm = val_rm_in;
      endcase
   end
`else
   assign rn = val_rn_in;
   assign rm = val_rm_in;
`endif

   assign branch_taken_out   = branch_taken_in;
   assign branch_address_out = pc_in +
      ADDR_W'({{(ADDR_W-26){signed_immediate_in[23]}}, signed_immediate_in, 2'b00});

   val2_generator #(.REG_W(REG_W), .SHOP_W(SHOP_W)) u_val2 (
      .val_rm        (rm),
      .shift_operand (shift_operand_in),
      .mem_op        (mem_read_in | mem_write_in),
      .immediate     (immediate_in),
      .val2          (val2)
   );

   // Subtracts run as Rn + ~Val2 + carry-in so sum[REG_W] is ARM's NOT-borrow.
   always_comb begin
      sum       = '0;
      result    = '0;
      cmd_valid = 1'b1;
      is_arith  = 1'b0;
      is_sub    = 1'b0;
      case (execute_command_in)
         EXE_MOV: result = val2;
         EXE_MVN: result = ~val2;
         EXE_AND: result = rn & val2;
         EXE_ORR: result = rn | val2;
         EXE_EOR: result = rn ^ val2;
         EXE_ADD: begin
            is_arith = 1'b1;
            sum      = {1'b0, rn} + {1'b0, val2};
         end
         EXE_ADC: begin
            is_arith = 1'b1;
            sum      = {1'b0, rn} + {1'b0, val2} + {{REG_W{1'b0}}, status.c};
         end
         EXE_SUB: begin
            is_arith = 1'b1;
            is_sub   = 1'b1;
            sum      = {1'b0, rn} + {1'b0, ~val2} + {{REG_W{1'b0}}, 1'b1};
         end
         EXE_SBC: begin
            is_arith = 1'b1;
            is_sub   = 1'b1;
            sum      = {1'b0, rn} + {1'b0, ~val2} + {{REG_W{1'b0}}, status.c};
         end
         default: cmd_valid = 1'b0;
      endcase
      if (is_arith)
         result = sum[REG_W-1:0];
   end

   always_comb begin
      nzcv_next = status;
      if (cmd_valid) begin
         nzcv_next.n = result[REG_W-1];
         nzcv_next.z = (result == '0);
         if (is_arith) begin
            nzcv_next.c = sum[REG_W];
            nzcv_next.v = ((rn[REG_W-1] ^ val2[REG_W-1]) == is_sub) &&
                          (result[REG_W-1] != rn[REG_W-1]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         status <= '0;
      else if (status_write_enable_in && !freeze)
         status <= nzcv_next;
   end

   assign status_out = status;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_result_out <= '0;
         store_data_out <= '0;
         dest_reg_out   <= '0;
         mem_read_out   <= 1'b0;
         mem_write_out  <= 1'b0;
         wb_enable_out  <= 1'b0;
      end else if (!freeze) begin
         alu_result_out <= result;
         store_data_out <= rm;
         dest_reg_out   <= dest_reg_in;
         mem_read_out   <= mem_read_in;
         mem_write_out  <= mem_write_in;
         wb_enable_out  <= wb_enable_in;
      end
   end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage against a behavioural ARM execute model.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic [31:0] pc_in;
   logic        mem_read_in, mem_write_in, wb_enable_in;
   logic        branch_taken_in, status_write_enable_in;
   logic [3:0]  execute_command_in;
   logic [31:0] val_rn_in, val_rm_in;
   logic        immediate_in;
   logic [23:0] signed_immediate_in;
   logic [11:0] shift_operand_in;
   logic [3:0]  dest_reg_in;
   logic        branch_taken_out;
   logic [31:0] branch_address_out;
   logic [3:0]  status_out;
   logic [31:0] alu_result_out, store_data_out;
   logic [3:0]  dest_reg_out;
   logic        mem_read_out, mem_write_out, wb_enable_out;
`ifdef FORWARDING_EN
   logic [1:0]  sel_src1 = 2'b00, sel_src2 = 2'b00;
   logic [31:0] mem_fwd_val = '0, wb_fwd_val = '0;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [3:0]  m_status;
   logic [31:0] exp_res, exp_store;
   logic [3:0]  exp_dst;
   logic        exp_mr, exp_mw, exp_wb;

   exe_stage dut (
      .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_enable_in(wb_enable_in),
      .branch_taken_in(branch_taken_in), .status_write_enable_in(status_write_enable_in),
      .execute_command_in(execute_command_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
      .immediate_in(immediate_in), .signed_immediate_in(signed_immediate_in),
      .shift_operand_in(shift_operand_in), .dest_reg_in(dest_reg_in),
`ifdef FORWARDING_EN
      .sel_src1(sel_src1), .sel_src2(sel_src2), .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
`endif
      .branch_taken_out(branch_taken_out), .branch_address_out(branch_address_out),
      .status_out(status_out), .alu_result_out(alu_result_out), .store_data_out(store_data_out),
      .dest_reg_out(dest_reg_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .wb_enable_out(wb_enable_out)
   );

   always #5 clk = ~clk;

   // Val2 from the ARM operand rules, one bit position at a time.
   function automatic logic [31:0] m_val2(input logic [31:0] rm, input logic [11:0] shop,
                                          input logic memop, input logic imm);
      logic [31:0] x;
      int amt;
      if (memop) return {20'd0, shop};
      if (imm) begin
         x = {24'd0, shop[7:0]};
         for (int i = 0; i < 2 * int'(shop[11:8]); i++) x = {x[0], x[31:1]};
         return x;
      end
      amt = int'(shop[11:7]);
      x = rm;
      case (shop[6:5])
         2'd0: x = rm * (32'd1 << amt);
         2'd1: x = rm / (32'd1 << amt);
         2'd2: for (int i = 0; i < amt; i++) x = {x[31], x[31:1]};
         default: for (int i = 0; i < amt; i++) x = {x[0], x[31:1]};
      endcase
      return x;
   endfunction

   // ALU with flags computed from wide signed/unsigned arithmetic.
   function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] rn, v2,
                                 input logic [3:0] st, output logic [31:0] res,
                                 output logic [3:0] f);
      longint ua, ub, sa, sb, s, ss;
      logic c, v, cin;
      ua = longint'(rn); ub = longint'(v2);
      sa = longint'($signed(rn)); sb = longint'($signed(v2));
      cin = st[1]; c = st[1]; v = st[0];
      s = 0; ss = 0; res = '0;
      case (cmd)
         4'd1: res = v2;
         4'd9: res = ~v2;
         4'd6: res = rn & v2;
         4'd7: res = rn | v2;
         4'd8: res = rn ^ v2;
         4'd2, 4'd3: begin
            s  = ua + ub + ((cmd == 4'd3) ? longint'(cin) : 0);
            ss = sa + sb + ((cmd == 4'd3) ? longint'(cin) : 0);
            c  = (s >= 64'sh1_0000_0000);
         end
         4'd4, 4'd5: begin
            s  = ua - ub - ((cmd == 4'd5) ? longint'(!cin) : 0);
            ss = sa - sb - ((cmd == 4'd5) ? longint'(!cin) : 0);
            c  = (s >= 0);
         end
         default: begin
            f = st;
            return;
         end
      endcase
      if (cmd inside {4'd2, 4'd3, 4'd4, 4'd5}) begin
         res = s[31:0];
         v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      f = {res[31], res == 32'd0, c, v};
   endfunction

   task automatic issue(input logic [3:0] cmd, input logic [31:0] rn, rm, input logic [11:0] shop,
                        input logic imm, mr, mw, swe, input logic [3:0] dst);
      logic [31:0] r;
      logic [3:0]  f;
      execute_command_in = cmd; val_rn_in = rn; val_rm_in = rm; shift_operand_in = shop;
      immediate_in = imm; mem_read_in = mr; mem_write_in = mw; wb_enable_in = ~mw;
      status_write_enable_in = swe; dest_reg_in = dst;
      m_alu(cmd, rn, m_val2(rm, shop, mr | mw, imm), m_status, r, f);
      exp_res = r; exp_store = rm; exp_dst = dst; exp_mr = mr; exp_mw = mw; exp_wb = ~mw;
      if (swe) m_status = f;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; freeze = 1'b0; pc_in = '0; mem_read_in = 0; mem_write_in = 0;
      wb_enable_in = 0; branch_taken_in = 0; status_write_enable_in = 0;
      execute_command_in = '0; val_rn_in = '0; val_rm_in = '0; immediate_in = 0;
      signed_immediate_in = '0; shift_operand_in = '0; dest_reg_in = '0;
      m_status = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if ({alu_result_out, store_data_out, dest_reg_out, mem_read_out, mem_write_out,
           wb_enable_out, status_out} !== '0)
         $display("FAIL reset: res=%h st=%h store=%h dst=%h ctl=%b%b%b required all zero",
                  alu_result_out, status_out, store_data_out, dest_reg_out,
                  mem_read_out, mem_write_out, wb_enable_out);
      else pass_cnt++;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_add_overflow();
      issue(4'd2, 32'h7FFF_FFFF, 32'd0, 12'h001, 1, 0, 0, 1, 4'd3);
      total_cnt++;
      if ({alu_result_out, status_out} !== {32'h8000_0000, 4'b1001})
         $display("FAIL add_ovf: got %h/%b required 80000000/1001", alu_result_out, status_out);
      else pass_cnt++;
   endtask

   task automatic test_sub_cmp();
      issue(4'd4, 32'd5, 32'd5, 12'h000, 0, 0, 0, 1, 4'd1);
      total_cnt++;
      if ({alu_result_out, status_out} !== {32'd0, 4'b0110})
         $display("FAIL sub_eq: got %h/%b required 00000000/0110", alu_result_out, status_out);
      else pass_cnt++;
      issue(4'd4, 32'd3, 32'd5, 12'h000, 0, 0, 0, 1, 4'd0);
      total_cnt++;
      if ({alu_result_out, status_out} !== {32'hFFFF_FFFE, 4'b1000})
         $display("FAIL cmp_lt: got %h/%b required fffffffe/1000", alu_result_out, status_out);
      else pass_cnt++;
   endtask

   task automatic test_val2_shift();
      issue(4'd1, 32'd0, 32'd0, 12'h4FF, 1, 0, 0, 0, 4'd2);
      total_cnt++;
      if (alu_result_out !== 32'hFF00_0000)
         $display("FAIL imm_rot: got %h required ff000000", alu_result_out);
      else pass_cnt++;
      issue(4'd1, 32'd0, 32'h8000_0000, 12'h240, 0, 0, 0, 0, 4'd2);
      total_cnt++;
      if (alu_result_out !== 32'hF800_0000)
         $display("FAIL asr4: got %h required f8000000", alu_result_out);
      else pass_cnt++;
   endtask

   task automatic test_ldr_str();
      issue(4'd2, 32'h100, 32'hDEAD_BEEF, 12'h804, 1, 1, 0, 0, 4'd7);
      total_cnt++;
      if ({alu_result_out, mem_read_out, mem_write_out, wb_enable_out, dest_reg_out} !==
          {32'h904, 1'b1, 1'b0, 1'b1, 4'd7})
         $display("FAIL ldr: got %h r%b w%b wb%b d%h required 904 r1 w0 wb1 d7",
                  alu_result_out, mem_read_out, mem_write_out, wb_enable_out, dest_reg_out);
      else pass_cnt++;
      issue(4'd2, 32'h200, 32'hCAFE_F00D, 12'hFFC, 0, 0, 1, 0, 4'd1);
      total_cnt++;
      if ({alu_result_out, store_data_out, mem_write_out, wb_enable_out} !==
          {32'h11FC, 32'hCAFE_F00D, 1'b1, 1'b0})
         $display("FAIL str: got %h data %h w%b wb%b required 11fc cafef00d w1 wb0",
                  alu_result_out, store_data_out, mem_write_out, wb_enable_out);
      else pass_cnt++;
   endtask

   task automatic test_branch();
      logic [31:0] exp;
      pc_in = 32'h40; signed_immediate_in = 24'hFFFFFE; branch_taken_in = 1'b1;
      #1;
      total_cnt++;
      if ({branch_address_out, branch_taken_out} !== {32'h38, 1'b1})
         $display("FAIL branch: got %h t%b required 00000038 t1", branch_address_out, branch_taken_out);
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         pc_in = $urandom; signed_immediate_in = 24'($urandom); branch_taken_in = 1'($urandom);
         exp = pc_in + 32'(longint'($signed(signed_immediate_in)) * 4);
         #1;
         total_cnt++;
         if ({branch_address_out, branch_taken_out} !== {exp, branch_taken_in})
            $display("FAIL branch_rand: got %h t%b required %h t%b",
                     branch_address_out, branch_taken_out, exp, branch_taken_in);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic        memop;
      for (int i = 0; i < 60; i++) begin
         b = $urandom;
         a = ($urandom_range(0, 3) == 0) ? b : 32'($urandom);
         memop = ($urandom_range(0, 5) == 0);
         issue(4'($urandom_range(0, 15)), a, b, 12'($urandom), 1'($urandom),
               memop, 1'b0, 1'($urandom), 4'($urandom));
         total_cnt++;
         if ({alu_result_out, status_out, store_data_out, dest_reg_out, mem_read_out, wb_enable_out} !==
             {exp_res, m_status, exp_store, exp_dst, exp_mr, exp_wb})
            $display("FAIL random[%0d] cmd=%h: got %h/%b/%h/%h required %h/%b/%h/%h", i,
                     execute_command_in, alu_result_out, status_out, store_data_out, dest_reg_out,
                     exp_res, m_status, exp_store, exp_dst);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      issue(4'd2, 32'hFFFF_FFFF, 32'd0, 12'h001, 1, 0, 0, 1, 4'd4);
      issue(4'd3, 32'd1, 32'd0, 12'h001, 1, 0, 0, 1, 4'd5);
      total_cnt++;
      if ({alu_result_out, status_out, dest_reg_out} !== {32'd3, 4'b0000, 4'd5})
         $display("FAIL adc_carry: got %h/%b d%h required 00000003/0000 d5",
                  alu_result_out, status_out, dest_reg_out);
      else pass_cnt++;
      issue(4'd11, 32'd9, 32'd9, 12'h000, 0, 0, 0, 1, 4'd6);
      total_cnt++;
      if ({alu_result_out, status_out} !== {32'd0, m_status})
         $display("FAIL bad_cmd: got %h/%b required 00000000/%b", alu_result_out, status_out, m_status);
      else pass_cnt++;
   endtask

   task automatic test_freeze_reset();
      logic [31:0] held_res;
      logic [3:0]  held_st;
      issue(4'd4, 32'd1, 32'd2, 12'h000, 0, 0, 0, 1, 4'd9);
      held_res = exp_res; held_st = m_status;
      freeze = 1'b1;
      execute_command_in = 4'd2; val_rn_in = 32'h1234; val_rm_in = 32'h55;
      status_write_enable_in = 1'b1; dest_reg_in = 4'd2; mem_read_in = 1'b1;
      pc_in = 32'h100; signed_immediate_in = 24'd4;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if ({alu_result_out, status_out, store_data_out, dest_reg_out, mem_read_out} !==
          {held_res, held_st, 32'd2, 4'd9, 1'b0})
         $display("FAIL freeze_hold: got %h/%b/%h/%h r%b required %h/%b/00000002/9 r0",
                  alu_result_out, status_out, store_data_out, dest_reg_out, mem_read_out,
                  held_res, held_st);
      else pass_cnt++;
      total_cnt++;
      if (branch_address_out !== 32'h110)
         $display("FAIL freeze_branch: got %h required 00000110", branch_address_out);
      else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if ({alu_result_out, store_data_out, dest_reg_out, mem_read_out, mem_write_out,
           wb_enable_out, status_out} !== '0)
         $display("FAIL async_rst: res=%h st=%b store=%h required all zero",
                  alu_result_out, status_out, store_data_out);
      else pass_cnt++;
      @(negedge clk); rst = 1'b0; freeze = 1'b0; m_status = 4'd0;
   endtask

`ifdef FORWARDING_EN
   task automatic test_forwarding();
      sel_src1 = 2'b01; sel_src2 = 2'b10; mem_fwd_val = 32'd100; wb_fwd_val = 32'd23;
      execute_command_in = 4'd2; val_rn_in = 32'd1; val_rm_in = 32'd1; shift_operand_in = '0;
      immediate_in = 0; mem_read_in = 0; mem_write_in = 0; status_write_enable_in = 0;
      @(posedge clk); #1;
      total_cnt++;
      if ({alu_result_out, store_data_out} !== {32'd123, 32'd23})
         $display("FAIL forwarding: got %h/%h required 0000007b/00000017", alu_result_out, store_data_out);
      else pass_cnt++;
      sel_src1 = 2'b00; sel_src2 = 2'b00;
   endtask
`endif

   initial begin
      test_reset();
      test_add_overflow();
      test_sub_cmp();
      test_val2_shift();
      test_ldr_str();
      test_branch();
      test_random();
      test_back_to_back();
`ifdef FORWARDING_EN
      test_forwarding();
`endif
      test_freeze_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline; consumes the ID/EXE pipeline register outputs.
- Contains the Val2 generator, the ALU, the branch-target adder, the architectural status register (NZCV) and the EXE/MEM pipeline register.
- Branch target and taken flag go combinationally to IF; registered results go to MEM; the status register value goes back to ID for condition checking.

Parameters:
- ADDR_W, 32, PC/address width
- REG_W, 32, register data width
- CMD_W, 4, execute command width
- SHOP_W, 12, shift-operand width
- RF_AW, 4, register-file address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- freeze  in  1  hazard stall; hold all state
- pc_in  in  ADDR_W  PC+4 of instruction in EXE
- mem_read_in, mem_write_in, wb_enable_in, branch_taken_in, status_write_enable_in  in  1 each  control from ID/EXE reg
- execute_command_in  in  CMD_W  ALU operation
- val_rn_in, val_rm_in  in  REG_W  operands
- immediate_in  in  1  I bit
- signed_immediate_in  in  24  branch offset
- shift_operand_in  in  SHOP_W  shifter operand
- dest_reg_in  in  RF_AW  destination
- branch_taken_out  out  1  combinational, equals branch_taken_in
- branch_address_out  out  ADDR_W  combinational branch target
- status_out  out  4  NZCV register {N,Z,C,V}
- alu_result_out  out  REG_W  registered ALU result / memory address
- store_data_out  out  REG_W  registered val_rm (STR data)
- dest_reg_out  out  RF_AW  registered
- mem_read_out, mem_write_out, wb_enable_out  out  1 each  registered

Behaviour:
- Branch: branch_address_out = pc_in + (sign_extend(signed_immediate_in) << 2), computed mod 2^ADDR_W, with no latency.
- Val2 generation, with priority in this order:
  - If mem_read_in|mem_write_in: Val2 = zero-extend(shift_operand[11:0]).
  - Else if immediate_in: Val2 = {24'b0, shop[7:0]} rotated right by 2*shop[11:8].
  - Else: shift val_rm_in by shop[11:7] using shop[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). A shift amount of 0 passes val_rm_in unchanged.
- ALU commands (Cin = status C):
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: Rn+Val2
  - 0011 ADC: Rn+Val2+Cin
  - 0100 SUB/CMP: Rn-Val2
  - 0101 SBC: Rn-Val2-~Cin
  - 0110 AND/TST: Rn&Val2
  - 0111 ORR: Rn|Val2
  - 1000 EOR: Rn^Val2
  - Any other code: result 0, flags unchanged.
  - LDR/STR arrive as ADD; Val2 comes from the mem rule above.
- Flags:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops: C = carry out of a 33-bit sum. Subtracts use ARM NOT-borrow, i.e. C = 1 when Rn>=Val2 (unsigned).
  - V = signed overflow.
  - Logical and move ops: C and V keep their prior values.
- Status register update:
  - Loads the new NZCV at posedge clk when status_write_enable_in & ~freeze.
  - Otherwise holds. Reset value 4'b0.
- EXE/MEM register:
  - At posedge clk with ~freeze: captures alu result, val_rm_in, dest_reg_in, mem_read_in, mem_write_in, wb_enable_in.
  - With freeze: holds.
  - Latency 1 cycle.
- Reset:
  - All registered outputs and status_out become 0 immediately on rst, including mid-stall.
  - rst overrides freeze and any write enable.
- Combinational outputs track their inputs even while freeze=1.

Optional Feature:
- Macro FORWARDING_EN.
- Enabled:
  - Adds ports sel_src1, sel_src2 (in, 2 bits each), mem_fwd_val and wb_fwd_val (in, REG_W).
  - Selection per operand: 00 = ID/EXE value, 01 = mem_fwd_val, 10 = wb_fwd_val, 11 = ID/EXE value. sel_src1 steers Rn; sel_src2 steers Rm, which also feeds store_data_out.
- Disabled: ports absent; operands come straight from val_rn_in/val_rm_in.

Decomposition:
- Shared package/defines holds the width constants (ADDRESS_LEN, REGISTER_LEN, EXECUTE_COMMAND_LEN, SHIFT_OPERAND_LEN, REGFILE_ADDRESS_LEN), the execute-command codes and the shift-type codes.
- One natural sub-module, val2_generator: purely combinational shifter/rotator.
- ALU, flags, status register and pipeline register stay in exe_stage.

Test Plan:
- ADD: Rn=0x7FFFFFFF, imm shop=0x001, S=1 -> alu_result_out=0x80000000 next cycle; status=1001 (N=1, V=1).
- SUB: Rn=5, Rm=5, register mode shop=0, S=1 -> result 0; status NZCV=0110. Then CMP 3-5 -> NZCV=1000.
- Val2 rotate: imm shop=0x4FF (rotate 8) -> MOV gives 0xFF000000. Register mode ASR #4 on Rm=0x80000000 -> 0xF8000000.
- LDR address: Rn=0x100, shop=0x804, mem_read_in=1 -> alu_result_out=0x904; mem_read_out=1.
- Branch: pc_in=0x40, signed_imm=0xFFFFFE -> branch_address_out=0x38 the same cycle.
- Freeze and reset: assert freeze with new inputs -> outputs/status hold. Assert rst mid-freeze -> all registered outputs and status go to 0 asynchronously.
